// File: rtl/imem_pkg.sv
// Shared types and address-decode helpers for the instruction-memory responder.
// Fetch and loader ports decode addresses through the same functions.
package imem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  // Byte offset from the base; wraps so addresses below the base land far out of range.
  function automatic logic [31:0] byte_off(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

  // Word-aligned and inside the DEPTH_WORDS*4 byte window; 64-bit compare avoids overflow.
  function automatic logic addr_ok(input logic [1:0] addr_lo, input logic [31:0] off,
                                   input int unsigned depth);
    return (addr_lo == 2'b00) && ({32'd0, off} < (64'(depth) << 2));
  endfunction

endpackage

// File: rtl/imem_sram.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, read-first.
// rdata only updates on a read strobe so it holds across writes.
module imem_sram #(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: 1-cycle SRAM fetch with fault reporting, loader write
// port that yields to fetches, and an optional NOP fill of the whole array after reset.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          DEPTH_WORDS    = 4096,
  parameter logic [31:0] NOP_INST       = NOP_DEFAULT,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_raddr,
  input  logic        i_re,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_err,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          run;
  logic          src_mem;
  logic [31:0]   hold_dat;
  logic [31:0]   sram_rdata;

  logic [31:0]   rd_off, ld_off;
  logic          rd_ok, ld_ok;
  logic [AW-1:0] rd_idx, ld_idx;
  logic          ld_fire, clearing;
  logic          sram_re, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;

  assign rd_off = byte_off(i_raddr, BASE_ADDR);
  assign ld_off = byte_off(i_ld_addr, BASE_ADDR);
  assign rd_ok  = addr_ok(i_raddr[1:0], rd_off, DEPTH_WORDS);
  assign ld_ok  = addr_ok(i_ld_addr[1:0], ld_off, DEPTH_WORDS);
  assign rd_idx = rd_off[AW+1:2];
  assign ld_idx = ld_off[AW+1:2];

  // Fetch owns the port whenever it is requesting; loader only gets idle cycles.
  assign o_ld_ready = run && !i_re;
  assign ld_fire    = i_ld_valid && o_ld_ready;

  // Gate on reset so nothing is written while reset is held.
  assign clearing   = i_rst_n && (state == S_CLEAR);

  assign sram_re    = run && i_re && rd_ok;
  assign sram_we    = clearing || (ld_fire && ld_ok);
  assign sram_addr  = run ? (i_re ? rd_idx : ld_idx) : clr_cnt;
  assign sram_wdata = run ? i_ld_data : NOP_INST;

  imem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (i_clk),
    .re   (sram_re),
    .we   (sram_we),
    .addr (sram_addr),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

  assign o_rdata = src_mem ? sram_rdata : hold_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt  <= '0;
      run      <= 1'b0;
      o_busy   <= CLEAR_ON_RESET;
      src_mem  <= 1'b0;
      hold_dat <= NOP_INST;
      o_fault  <= 1'b0;
      o_ld_err <= 1'b0;
    end else begin
      o_ld_err <= ld_fire && !ld_ok;

      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST_IDX) begin
            state   <= S_RUN;
            run     <= 1'b1;
            o_busy  <= 1'b0;
            clr_cnt <= '0;
          end
        end
        S_RUN: begin
          run    <= 1'b1;
          o_busy <= 1'b0;
        end
        default: state <= S_RUN;
      endcase

      // Output is either the SRAM read register or a held NOP; i_re low keeps both.
      if (i_re) begin
        if (!run) begin
          src_mem  <= 1'b0;
          hold_dat <= NOP_INST;
          o_fault  <= 1'b0;
        end else if (rd_ok) begin
          src_mem  <= 1'b1;
          o_fault  <= 1'b0;
        end else begin
          src_mem  <= 1'b0;
          hold_dat <= NOP_INST;
          o_fault  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-fetch read interface: accepts a fetch address plus read-enable and returns the instruction word from on-chip single-port SRAM.
- Sits between the fetch stage and instruction storage.
- Provides a valid/ready loader port so a debug/boot agent can write the program image.
- Includes a post-reset clear sequence and address-fault reporting.

Parameters:
- BASE_ADDR, 32'h80000000, byte address mapped to word 0; equals the core reset vector.
- DEPTH_WORDS, 4096, number of 32-bit words (power of two, >=2).
- NOP_INST, 32'h00000013, word returned on reset, clear, fault or idle.
- CLEAR_ON_RESET, 1, when 1 the memory is filled with NOP_INST after reset.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_raddr  in  32  fetch byte address
- i_re  in  1  fetch read enable; low = hold (stall)
- o_rdata  out  32  instruction word, registered
- o_fault  out  1  registered; high with o_rdata when the fetch address was misaligned or out of range
- i_ld_valid  in  1  loader write request
- o_ld_ready  out  1  loader may write this cycle
- i_ld_addr  in  32  loader byte address
- i_ld_data  in  32  loader write data
- o_ld_err  out  1  one-cycle pulse: accepted loader write was out of range or misaligned and was dropped
- o_busy  out  1  clear sequence in progress

Behaviour:
- Clock and reset: clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values: o_rdata=NOP_INST, o_fault=0, o_ld_err=0, o_ld_ready=0, o_busy=CLEAR_ON_RESET.
- FSM states: S_CLEAR, S_RUN.
  - Reset enters S_CLEAR if CLEAR_ON_RESET, else S_RUN.
  - S_CLEAR: clear counter runs 0..DEPTH_WORDS-1, writing NOP_INST one word per cycle; o_busy=1; o_ld_ready=0.
  - Fetches during S_CLEAR return NOP_INST with o_fault=0 and never touch the SRAM.
  - After the last word (counter==DEPTH_WORDS-1) the FSM moves to S_RUN on the next edge. Clear takes exactly DEPTH_WORDS cycles.
- Address decode:
  - offset = i_raddr - BASE_ADDR (32-bit, wraps).
  - Valid iff i_raddr[1:0]==0 and offset < DEPTH_WORDS*4.
  - Index = offset[log2(DEPTH_WORDS)+1:2].
  - The loader uses the same rules.
- Fetch, 1-cycle latency: if i_re=1 at posedge N, o_rdata/o_fault reflect that address after edge N.
  - Valid address: o_rdata=mem[index], o_fault=0.
  - Invalid address: o_rdata=NOP_INST, o_fault=1; no SRAM access.
  - i_re=0: o_rdata and o_fault hold their previous values.
- Arbitration, single port, fetch has priority:
  - In S_RUN, o_ld_ready = !i_re (combinational).
  - A write occurs when i_ld_valid && o_ld_ready.
  - Loader data is written to the SRAM on that edge. A subsequent fetch of that address returns the new data.
  - Out-of-range or misaligned write: handshake still completes, write dropped, o_ld_err=1 for the following cycle only.
- No same-cycle read/write collision is possible; read-first SRAM semantics are irrelevant but the SRAM is still read-first.
- Reset asserted mid-clear or mid-load:
  - All outputs return to reset values immediately.
  - The clear restarts from word 0.
  - An in-flight loader write on the same edge is not performed.
- Wrap-around: an address below BASE_ADDR wraps offset to a large value and faults. BASE_ADDR+DEPTH_WORDS*4 faults; the last word does not.

Decomposition:
- Package imem_pkg: FSM state enum (S_CLEAR, S_RUN), NOP_INST default constant, address-valid/index helper function.
- Sub-module imem_sram: single-port synchronous RAM (we, addr, wdata, rdata, read-first), DEPTH_WORDS x 32.
- The responder contains the FSM, decode, arbitration and output registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH_WORDS=16 -> o_busy=1 for exactly 16 cycles. Fetch 32'h80000000 during clear -> o_rdata=32'h00000013, o_fault=0. After clear, o_ld_ready=1 when i_re=0.
- Loader writes 32'hDEADBEEF to 32'h80000008, then fetch 32'h80000008 -> next cycle o_rdata=32'hDEADBEEF, o_fault=0.
- Fetch 32'h80000002 (misaligned), 32'h80000040 (DEPTH 16, out of range) and 32'h7FFFFFFC -> o_rdata=32'h00000013, o_fault=1 each. Fetch 32'h8000003C -> o_fault=0.
- i_re=1 with i_ld_valid=1 -> o_ld_ready=0, no write. Drop i_re -> write accepted same cycle. Then i_re=0 for 3 cycles -> o_rdata held unchanged.
- Loader write to 32'h90000000 -> handshake completes, o_ld_err pulses for exactly 1 cycle, memory unchanged.
- Assert i_rst_n low at clear count 7 -> outputs reset immediately. Release -> clear restarts, o_busy high for full 16 cycles.
